raster_fb_writer: RTL and testbench
===================================

// Module: raster_fb_writer
// PURPOSE
//   Pixel sink at the output end of the raster pipeline. It accepts the (color, x, y) pixel stream
//   from raster over a vld/rdy handshake and writes each pixel into a single-port framebuffer SRAM.
//   It also services a full-frame clear and a raster-order scan-out stream for display or dump.
//   It is the only agent on the framebuffer memory port.
// PARAMETERS
//   FB_W_BITS    5   log2 framebuffer width in pixels (default 32 = 2 tiles of `TILE_WIDTH)
//   FB_H_BITS    5   log2 framebuffer height in pixels
//   CLEAR_COLOR  0   value written by the clear operation; width `COLOR_BITS
// PORTS
//   clk         in   1                    clock
//   rst_n       in   1                    asynchronous active-low reset
//   px_vld      in   1                    pixel valid (driven by raster vld_out)
//   px_rdy      out  1                    pixel ready (drives raster rdy_out)
//   px_color    in   `COLOR_BITS          pixel color
//   px_x,px_y   in   `FX_TOTAL_BITS       signed fixed-point pixel coordinates
//   clear_start in   1                    one-cycle request to fill the framebuffer with CLEAR_COLOR
//   scan_start  in   1                    one-cycle request to stream out the whole frame
//   busy        out  1                    high in CLEAR or SCAN
//   done        out  1                    one-cycle pulse when CLEAR or SCAN completes
//   mem_en      out  1                    memory access enable
//   mem_we      out  1                    1 = write, 0 = read
//   mem_addr    out  FB_W_BITS+FB_H_BITS  word address, computed as {iy, ix}
//   mem_wdata   out  `COLOR_BITS          write data
//   mem_rdata   in   `COLOR_BITS          read data, valid exactly 1 cycle after a read
//   scan_vld    out  1                    scan beat valid
//   scan_rdy    in   1                    scan beat ready
//   scan_color  out  `COLOR_BITS          scan pixel color
//   scan_last   out  1                    asserted with the final scan beat (address FB_AREA-1)
//   drop_cnt    out  16                   saturating count of dropped out-of-range pixels
// BEHAVIOUR
//   Reset: state=IDLE. All outputs 0 except px_rdy, which goes to 1 on the first clock after
//     rst_n rises. Reset asserted mid-CLEAR or mid-SCAN aborts the operation: FIFO emptied,
//     counters cleared.
//   FSM states IDLE, CLEAR, SCAN. px_rdy = (state==IDLE) and no start request in this cycle.
//   Start priority in IDLE: clear_start > scan_start > pixel accept. Start requests outside IDLE
//     are ignored and not queued.
//   Pixel accept:
//     - Handshake is px_vld & px_rdy.
//     - ix = px_x >>> `FX_FRAC_BITS, iy = px_y >>> `FX_FRAC_BITS.
//     - If ix<0, iy<0, ix>=2^FB_W_BITS or iy>=2^FB_H_BITS, the pixel is dropped and drop_cnt
//       increments (saturates at 16'hFFFF).
//     - Otherwise the write is registered and issued on the next cycle: mem_en=1, mem_we=1,
//       mem_addr={iy,ix}, mem_wdata=px_color.
//     - Throughput is 1 pixel per cycle. Back-to-back writes to the same address: last one wins.
//   CLEAR: one write per cycle to addresses 0..FB_AREA-1 with data CLEAR_COLOR. After the last
//     write: done pulses and state returns to IDLE. Takes FB_AREA cycles.
//   SCAN:
//     - Issues reads at addresses 0..FB_AREA-1 in order.
//     - A read is issued only when (fifo_count + reads_in_flight) < 2; this keeps the 2-entry
//       output FIFO from overflowing under backpressure.
//     - mem_rdata is pushed into the FIFO one cycle after its read. scan_vld = FIFO not empty.
//     - A beat transfers on scan_vld & scan_rdy. scan_rdy low stalls the stream with no loss and
//       no duplication.
//     - scan_last rides with the data of address FB_AREA-1.
//     - After the last beat transfers: done pulses and state returns to IDLE.
//     - With scan_rdy held at 1, sustained throughput is 1 beat per cycle after 1 cycle of
//       initial latency.
//   Address counter is FB_W_BITS+FB_H_BITS wide. Terminal detection uses the all-ones value;
//     the counter never wraps.
// STRUCTURE
//   raster_defines.svh gains `FB_W_BITS_DEF and `FB_H_BITS_DEF.
//   struct_defines.svh gains typedef fb_state_t (IDLE/CLEAR/SCAN) and typedef pixel_t
//     {color, x, y}.
//   Sub-module fb_scan_fifo: 2-entry vld/rdy FIFO holding {color,last}, exposing its count.
// TESTING
//   1. Reset, then idle 3 cycles -> px_rdy=1; busy, done, mem_en, scan_vld=0; drop_cnt=0.
//   2. Pixel px_x=3<<FRAC, px_y=2<<FRAC, color=4 -> next cycle mem_we=1, mem_addr=67, mem_wdata=4.
//   3. Pixels at x=-1<<FRAC and at x=32<<FRAC -> no mem_en; drop_cnt=2; px_rdy stays 1.
//   4. clear_start with px_vld=1 in the same cycle -> px not accepted; 1024 writes to
//      addresses 0..1023 with data 0; done pulse; then the pending pixel is accepted.
//   5. Write colors 1..4 to addresses 0..3, then scan with scan_rdy toggling every cycle
//      -> 1024 ordered beats, first four are 1,2,3,4; scan_last only on beat 1024; done pulse.
//   6. rst_n low during SCAN beat 100 -> scan_vld=0 immediately; after release state=IDLE and
//      a new scan starts again at address 0.

Source files
------------

// File: rtl/raster_fb_writer_pkg.sv
// Shared types and constants for the framebuffer writer.
package raster_fb_writer_pkg;

  localparam int unsigned COLOR_BITS    = 8;
  localparam int unsigned FX_FRAC_BITS  = 4;
  localparam int unsigned FX_TOTAL_BITS = 16;
  localparam int unsigned FB_W_BITS_DEF = 5;
  localparam int unsigned FB_H_BITS_DEF = 5;

  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_CLEAR = 2'd1,
    FB_SCAN  = 2'd2
  } fb_state_t;

  typedef struct packed {
    logic [COLOR_BITS-1:0]    color;
    logic [FX_TOTAL_BITS-1:0] x;
    logic [FX_TOTAL_BITS-1:0] y;
  } pixel_t;

  typedef struct packed {
    logic [COLOR_BITS-1:0] color;
    logic                  last;
  } scan_beat_t;

  // Signed fixed-point coordinate to integer pixel coordinate (floor).
  function automatic logic [FX_TOTAL_BITS-1:0] fx_to_int(input logic [FX_TOTAL_BITS-1:0] v);
    return FX_TOTAL_BITS'($signed(v) >>> FX_FRAC_BITS);
  endfunction

endpackage

// File: rtl/raster_fb_writer_scan_fifo.sv
// Two-entry vld/rdy FIFO for scan-out beats; the writer guarantees no push when full.
module raster_fb_writer_scan_fifo
  import raster_fb_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_vld_i,
  input  scan_beat_t in_data_i,
  output logic       out_vld_o,
  input  logic       out_rdy_i,
  output scan_beat_t out_data_o,
  output logic [1:0] count_o
);

  scan_beat_t slot_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       pop;

  assign out_vld_o  = (count_q != 2'd0);
  assign pop        = out_vld_o && out_rdy_i;
  assign out_data_o = slot_q[rd_ptr_q];
  assign count_o    = count_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) slot_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (in_vld_i) begin
        slot_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, in_vld_i} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/raster_fb_writer.sv
// Framebuffer sink: pixel writes, full-frame clear and raster-order scan-out.
module raster_fb_writer
  import raster_fb_writer_pkg::*;
#(
  parameter int unsigned           FB_W_BITS   = FB_W_BITS_DEF,
  parameter int unsigned           FB_H_BITS   = FB_H_BITS_DEF,
  parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           px_vld,
  output logic                           px_rdy,
  input  logic [COLOR_BITS-1:0]          px_color,
  input  logic [FX_TOTAL_BITS-1:0]       px_x,
  input  logic [FX_TOTAL_BITS-1:0]       px_y,
  input  logic                           clear_start,
  input  logic                           scan_start,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [FB_W_BITS+FB_H_BITS-1:0] mem_addr,
  output logic [COLOR_BITS-1:0]          mem_wdata,
  input  logic [COLOR_BITS-1:0]          mem_rdata,
  output logic                           scan_vld,
  input  logic                           scan_rdy,
  output logic [COLOR_BITS-1:0]          scan_color,
  output logic                           scan_last,
  output logic [15:0]                    drop_cnt
);

  localparam int unsigned AW = FB_W_BITS + FB_H_BITS;

  fb_state_t             state_q;
  logic                  rdy_en_q;
  logic [AW-1:0]         ptr_q;
  logic                  rd_done_q;
  logic                  pend_q;
  logic                  pend_last_q;
  logic                  wr_vld_q;
  logic [AW-1:0]         wr_addr_q;
  logic [COLOR_BITS-1:0] wr_data_q;
  logic                  done_q;
  logic [15:0]           drop_q;

  pixel_t                   px;
  logic [FX_TOTAL_BITS-1:0] ix, iy;
  logic                     in_range, accept, issue, scan_pop;
  logic [1:0]               fifo_cnt;
  logic [2:0]               occ;
  scan_beat_t               fifo_in, fifo_out;

  assign px       = {px_color, px_x, px_y};
  assign ix       = fx_to_int(px.x);
  assign iy       = fx_to_int(px.y);
  // Upper bits all zero covers both the negative and the too-large cases.
  assign in_range = (ix[FX_TOTAL_BITS-1:FB_W_BITS] == '0) && (iy[FX_TOTAL_BITS-1:FB_H_BITS] == '0);
  assign px_rdy   = rdy_en_q && (state_q == FB_IDLE) && !clear_start && !scan_start;
  assign accept   = px_vld && px_rdy;

  // Reads are issued combinationally so data lands in the FIFO one cycle later; the
  // occupancy counts a pop in this cycle as freeing a slot, which keeps 1 beat/cycle.
  assign scan_pop = scan_vld && scan_rdy;
  assign occ      = {1'b0, fifo_cnt} + {2'b0, pend_q} - {2'b0, scan_pop};
  assign issue    = (state_q == FB_SCAN) && !rd_done_q && (occ < 3'd2);
  assign fifo_in  = '{color: mem_rdata, last: pend_last_q};

  assign busy       = (state_q != FB_IDLE);
  assign done       = done_q;
  assign drop_cnt   = drop_q;
  assign scan_color = scan_vld ? fifo_out.color : '0;
  assign scan_last  = scan_vld && fifo_out.last;

  raster_fb_writer_scan_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (pend_q),
    .in_data_i (fifo_in),
    .out_vld_o (scan_vld),
    .out_rdy_i (scan_rdy),
    .out_data_o(fifo_out),
    .count_o   (fifo_cnt)
  );

  // Memory port mux: only one agent owns the SRAM in each state.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = wr_addr_q;
    mem_wdata = wr_data_q;
    unique case (state_q)
      FB_IDLE: begin
        mem_en = wr_vld_q;
        mem_we = wr_vld_q;
      end
      FB_CLEAR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = CLEAR_COLOR;
      end
      FB_SCAN: begin
        mem_en   = issue;
        mem_addr = ptr_q;
      end
      default: ;
    endcase
  end

  // Control FSM with registered pixel write, address counter and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FB_IDLE;
      rdy_en_q    <= 1'b0;
      ptr_q       <= '0;
      rd_done_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      rdy_en_q    <= 1'b1;
      done_q      <= 1'b0;
      wr_vld_q    <= 1'b0;
      pend_q      <= issue;
      pend_last_q <= issue && (ptr_q == '1);
      unique case (state_q)
        FB_IDLE: begin
          if (clear_start) begin
            state_q <= FB_CLEAR;
            ptr_q   <= '0;
          end else if (scan_start) begin
            state_q   <= FB_SCAN;
            ptr_q     <= '0;
            rd_done_q <= 1'b0;
          end else if (accept) begin
            if (in_range) begin
              wr_vld_q  <= 1'b1;
              wr_addr_q <= {iy[FB_H_BITS-1:0], ix[FB_W_BITS-1:0]};
              wr_data_q <= px.color;
            end else if (drop_q != '1) begin
              drop_q <= drop_q + 16'd1;
            end
          end
        end
        FB_CLEAR: begin
          if (ptr_q == '1) begin
            state_q <= FB_IDLE;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        FB_SCAN: begin
          if (issue) begin
            if (ptr_q == '1) rd_done_q <= 1'b1;
            else             ptr_q     <= ptr_q + AW'(1);
          end
          if (scan_pop && fifo_out.last) begin
            state_q <= FB_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= FB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_fb_writer.sv
// Self-checking bench for raster_fb_writer with an SRAM model and scoreboards.
module tb_raster_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        px_vld = 1'b0;
  logic        px_rdy;
  logic [7:0]  px_color = '0;
  logic [15:0] px_x = '0;
  logic [15:0] px_y = '0;
  logic        clear_start = 1'b0;
  logic        scan_start = 1'b0;
  logic        busy, done, mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        scan_vld;
  logic        scan_rdy = 1'b0;
  logic [7:0]  scan_color;
  logic        scan_last;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         vld;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  wr_exp_t    wr_q[$];
  logic [8:0] scan_q[$];
  logic [7:0] fb_mem [1024];
  logic [7:0] ref_fb [1024];

  raster_fb_writer #(.FB_W_BITS(5), .FB_H_BITS(5), .CLEAR_COLOR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .px_vld(px_vld), .px_rdy(px_rdy), .px_color(px_color),
    .px_x(px_x), .px_y(px_y), .clear_start(clear_start), .scan_start(scan_start),
    .busy(busy), .done(done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .scan_vld(scan_vld), .scan_rdy(scan_rdy),
    .scan_color(scan_color), .scan_last(scan_last), .drop_cnt(drop_cnt)
  );

  initial forever #5 clk = ~clk;

  // Single-port SRAM: read data valid the cycle after the read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) fb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata        <= fb_mem[mem_addr];
    end
  end

  function automatic logic [15:0] fx(input int v);
    return 16'(v * 16);
  endfunction

  function automatic bit model_in_range(input int xi, input int yi);
    return (xi >= 0) && (xi < 32) && (yi >= 0) && (yi < 32);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (px_rdy !== 1'b0) begin failures++; $display("FAIL reset_px_rdy_low got=%b exp=0", px_rdy); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (px_rdy !== 1'b1) begin failures++; $display("FAIL reset_px_rdy got=%b exp=1", px_rdy); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
    checks++; if (scan_vld !== 1'b0) begin failures++; $display("FAIL reset_scan_vld got=%b exp=0", scan_vld); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_pixel_write();
    wr_exp_t e;
    @(posedge clk); #1;
    px_vld = 1'b1; px_color = 8'd4; px_x = fx(3); px_y = fx(2);
    wr_q.push_back('{vld: 1'b1, addr: 10'(2 * 32 + 3), data: 8'd4});
    ref_fb[2 * 32 + 3] = 8'd4;
    @(negedge clk);
    checks++; if (px_rdy !== 1'b1) begin failures++; $display("FAIL pix_rdy got=%b exp=1", px_rdy); end
    @(posedge clk); #1;
    px_vld = 1'b0;
    @(negedge clk);
    e = wr_q.pop_front();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, e.addr, e.data}) begin
      failures++; $display("FAIL pix_write got en=%b we=%b addr=%0d data=%0d exp en=1 we=1 addr=%0d data=%0d",
                           mem_en, mem_we, mem_addr, mem_wdata, e.addr, e.data);
    end
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL pix_single_write got mem_en=%b exp=0", mem_en); end
  endtask

  task automatic test_drop();
    @(posedge clk); #1;
    px_vld = 1'b1; px_color = 8'hAA; px_x = fx(-1); px_y = fx(0);
    @(negedge clk);
    checks++; if (px_rdy !== 1'b1) begin failures++; $display("FAIL drop_rdy0 got=%b exp=1", px_rdy); end
    @(posedge clk); #1;
    px_x = fx(32);
    @(negedge clk);
    checks++; if (px_rdy !== 1'b1) begin failures++; $display("FAIL drop_rdy1 got=%b exp=1", px_rdy); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL drop_no_write0 got mem_en=%b exp=0", mem_en); end
    @(posedge clk); #1;
    px_vld = 1'b0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL drop_no_write1 got mem_en=%b exp=0", mem_en); end
    checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL drop_cnt got=%0d exp=2", drop_cnt); end
  endtask

  task automatic test_clear();
    int      wr_idx = 0;
    bit      got_done = 1'b0;
    wr_exp_t e;
    @(posedge clk); #1;
    clear_start = 1'b1; px_vld = 1'b1; px_color = 8'h55; px_x = fx(7); px_y = fx(1);
    @(negedge clk);
    checks++; if (px_rdy !== 1'b0) begin failures++; $display("FAIL clear_blocks_px got=%b exp=0", px_rdy); end
    @(posedge clk); #1;
    clear_start = 1'b0;
    for (int cyc = 0; cyc < 1100 && !got_done; cyc++) begin
      @(negedge clk);
      scan_start = (cyc == 10);
      if (cyc == 0) begin
        checks++; if ({busy, px_rdy} !== 2'b10) begin failures++; $display("FAIL clear_busy got busy=%b px_rdy=%b exp busy=1 px_rdy=0", busy, px_rdy); end
      end
      if (done) begin
        got_done = 1'b1;
      end else begin
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 10'(wr_idx), 8'h00}) begin
          failures++; $display("FAIL clear_write got en=%b we=%b addr=%0d data=%0h exp en=1 we=1 addr=%0d data=0",
                               mem_en, mem_we, mem_addr, mem_wdata, wr_idx);
        end
        wr_idx++;
      end
    end
    scan_start = 1'b0;
    checks++; if (!got_done) begin failures++; $display("FAIL clear_done_timeout got=0 exp=1"); end
    checks++; if (wr_idx != 1024) begin failures++; $display("FAIL clear_count got=%0d exp=1024", wr_idx); end
    checks++; if (px_rdy !== 1'b1) begin failures++; $display("FAIL clear_then_rdy got=%b exp=1", px_rdy); end
    for (int k = 0; k < 1024; k++) ref_fb[k] = 8'h00;
    ref_fb[1 * 32 + 7] = 8'h55;
    wr_q.push_back('{vld: 1'b1, addr: 10'(1 * 32 + 7), data: 8'h55});
    @(posedge clk); #1;
    px_vld = 1'b0;
    @(negedge clk);
    e = wr_q.pop_front();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, e.addr, e.data}) begin
      failures++; $display("FAIL clear_pending_px got en=%b we=%b addr=%0d data=%0h exp addr=%0d data=%0h",
                           mem_en, mem_we, mem_addr, mem_wdata, e.addr, e.data);
    end
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL clear_start_ignored got busy=%b done=%b exp 00", busy, done); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    int      tc [N] = '{1, 2, 9, 3, 8'h77, 4};
    int      tx [N] = '{0, 1, 2, 2, 5, 3};
    int      ty [N] = '{0, 0, 0, 0, -1, 0};
    wr_exp_t e;
    for (int i = 0; i <= N; i++) begin
      @(posedge clk); #1;
      if (i < N) begin
        px_vld = 1'b1; px_color = 8'(tc[i]); px_x = fx(tx[i]); px_y = fx(ty[i]);
        if (model_in_range(tx[i], ty[i])) begin
          wr_q.push_back('{vld: 1'b1, addr: 10'(ty[i] * 32 + tx[i]), data: 8'(tc[i])});
          ref_fb[ty[i] * 32 + tx[i]] = 8'(tc[i]);
        end else begin
          wr_q.push_back('{vld: 1'b0, addr: '0, data: '0});
        end
      end else begin
        px_vld = 1'b0;
      end
      @(negedge clk);
      if (i < N) begin
        checks++; if (px_rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy[%0d] got=%b exp=1", i, px_rdy); end
      end
      if (i > 0) begin
        e = wr_q.pop_front();
        checks++;
        if (e.vld) begin
          if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, e.addr, e.data}) begin
            failures++; $display("FAIL b2b_write[%0d] got en=%b addr=%0d data=%0h exp en=1 addr=%0d data=%0h",
                                 i - 1, mem_en, mem_addr, mem_wdata, e.addr, e.data);
          end
        end else if (mem_en !== 1'b0) begin
          failures++; $display("FAIL b2b_drop[%0d] got mem_en=%b exp=0", i - 1, mem_en);
        end
      end
    end
    checks++; if (drop_cnt !== 16'd3) begin failures++; $display("FAIL b2b_drop_cnt got=%0d exp=3", drop_cnt); end
  endtask

  task automatic test_scan_backpressure();
    int         beats = 0;
    bit         got_done = 1'b0;
    logic [8:0] exp;
    for (int k = 0; k < 1024; k++) scan_q.push_back({(k == 1023) ? 1'b1 : 1'b0, ref_fb[k]});
    @(posedge clk); #1;
    scan_start = 1'b1; scan_rdy = 1'b0;
    @(posedge clk); #1;
    scan_start = 1'b0;
    for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++; if ({busy, px_rdy} !== 2'b10) begin failures++; $display("FAIL scan_busy got busy=%b px_rdy=%b exp 10", busy, px_rdy); end
      end
      if (done) begin
        got_done = 1'b1;
      end else if (scan_vld && scan_rdy) begin
        checks++;
        if (scan_q.size() == 0) begin
          failures++; $display("FAIL scan_extra_beat got beat=%0d exp none", beats);
        end else begin
          exp = scan_q.pop_front();
          if ({scan_last, scan_color} !== exp) begin
            failures++; $display("FAIL scan_beat[%0d] got last=%b color=%0h exp last=%b color=%0h",
                                 beats, scan_last, scan_color, exp[8], exp[7:0]);
          end
        end
        beats++;
      end
      @(posedge clk); #1;
      scan_rdy = ~scan_rdy;
    end
    checks++; if (!got_done) begin failures++; $display("FAIL scan_done_timeout got=0 exp=1"); end
    checks++; if (beats != 1024) begin failures++; $display("FAIL scan_beats got=%0d exp=1024", beats); end
    @(negedge clk);
    checks++; if ({busy, done, scan_vld} !== 3'b000) begin failures++; $display("FAIL scan_idle_after got busy=%b done=%b vld=%b exp 000", busy, done, scan_vld); end
    scan_rdy = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int  beats = 0;
    int  stalls = 0;
    bit  started = 1'b0;
    bit  aborted = 1'b0;
    bit  got_done = 1'b0;
    @(posedge clk); #1;
    scan_start = 1'b1; scan_rdy = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    for (int cyc = 0; cyc < 400 && !aborted; cyc++) begin
      @(negedge clk);
      if (scan_vld) begin
        started = 1'b1;
        if (beats == 99) begin
          rst_n = 1'b0; #1;
          checks++; if (scan_vld !== 1'b0) begin failures++; $display("FAIL rst_scan_vld got=%b exp=0", scan_vld); end
          checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
          aborted = 1'b1;
        end else begin
          checks++;
          if (scan_color !== ref_fb[beats]) begin failures++; $display("FAIL rs_beat[%0d] got=%0h exp=%0h", beats, scan_color, ref_fb[beats]); end
          beats++;
        end
      end else if (started) begin
        stalls++;
      end
    end
    checks++; if (!aborted) begin failures++; $display("FAIL rs_reach_beat100 got beats=%0d exp=99", beats); end
    checks++; if (stalls != 0) begin failures++; $display("FAIL rs_throughput got stalls=%0d exp=0", stalls); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({px_rdy, busy, drop_cnt} !== {1'b1, 1'b0, 16'd0}) begin
      failures++; $display("FAIL rs_idle got px_rdy=%b busy=%b drop=%0d exp 1 0 0", px_rdy, busy, drop_cnt);
    end
    @(posedge clk); #1;
    scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
      end else if (scan_vld) begin
        checks++;
        if (beats >= 1024) begin
          failures++; $display("FAIL rs2_extra_beat got beat=%0d exp none", beats);
        end else if ({scan_last, scan_color} !== {(beats == 1023) ? 1'b1 : 1'b0, ref_fb[beats]}) begin
          failures++; $display("FAIL rs2_beat[%0d] got last=%b color=%0h exp color=%0h", beats, scan_last, scan_color, ref_fb[beats]);
        end
        beats++;
      end
    end
    checks++; if (!got_done) begin failures++; $display("FAIL rs2_done_timeout got=0 exp=1"); end
    checks++; if (beats != 1024) begin failures++; $display("FAIL rs2_beats got=%0d exp=1024", beats); end
    scan_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pixel_write();
    test_drop();
    test_clear();
    test_back_to_back();
    test_scan_backpressure();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
